// File: rtl/lvds_frame_pkg.sv
// Shared framing constants and encodings for the LVDS RX deframer and TX framer.
// Frame layout, MSB first: 10 | I[12:0] | type | 01 | Q[12:0] | 0.
package lvds_frame_pkg;

    localparam int FRAME_BITS  = 32;
    localparam int PAIRS       = 16;
    localparam int SAMPLE_W    = 13;
    localparam int PH_W        = $clog2(PAIRS);

    localparam logic [1:0] SYNC_HI = 2'b10;
    localparam logic [1:0] SYNC_LO = 2'b01;
    localparam int SYNC_HI_MSB = 31;
    localparam int SYNC_LO_MSB = 15;

    localparam int I_MSB    = 29;
    localparam int I_LSB    = 17;
    localparam int TYPE_BIT = 16;
    localparam int Q_MSB    = 13;
    localparam int Q_LSB    = 1;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } rx_state_t;

    typedef enum logic [1:0] {
        CLS_IDLE,
        CLS_DATA,
        CLS_EOM,
        CLS_BAD
    } frame_cls_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [SAMPLE_W-1:0] i,
        input logic [SAMPLE_W-1:0] q,
        input logic                is_data
    );
        return {SYNC_HI, i, is_data, SYNC_LO, q, 1'b0};
    endfunction

endpackage

// File: rtl/lvds_rx_deframer_if.sv
// Deframer bus: DDR pair in, unpacked samples and link status out.
interface lvds_rx_deframer_if
    import lvds_frame_pkg::*;
#(
    parameter int ERR_W = 16
);
    logic [1:0]          i_rx_d;
    logic [SAMPLE_W-1:0] o_i;
    logic [SAMPLE_W-1:0] o_q;
    logic                o_valid;
    logic                o_eom;
    logic                o_locked;
    logic                o_lost;
    logic [ERR_W-1:0]    o_err_cnt;

    modport master (
        input  i_rx_d,
        output o_i, o_q, o_valid, o_eom, o_locked, o_lost, o_err_cnt
    );

    modport slave (
        output i_rx_d,
        input  o_i, o_q, o_valid, o_eom, o_locked, o_lost, o_err_cnt
    );

endinterface

// File: rtl/lvds_frame_classify.sv
// Combinational frame classifier: looks at the full 32-bit window and
// reports IDLE / DATA / EOM / BAD.
module lvds_frame_classify
    import lvds_frame_pkg::*;
(
    input  logic [FRAME_BITS-1:0] sr,
    output frame_cls_t            cls
);
    logic sync_ok;

    always_comb begin
        sync_ok = (sr[SYNC_HI_MSB -: 2] == SYNC_HI) &&
                  (sr[SYNC_LO_MSB -: 2] == SYNC_LO) &&
                  !sr[0];
        cls = CLS_BAD;
        if (sr == '0) begin
            cls = CLS_IDLE;
        end else if (sync_ok && sr[TYPE_BIT]) begin
            cls = CLS_DATA;
        end else if (sync_ok && (sr[I_MSB:I_LSB] == '0) && (sr[Q_MSB:Q_LSB] == '0)) begin
            cls = CLS_EOM;
        end
    end

endmodule

// File: rtl/lvds_rx_deframer.sv
// LVDS RX deframer: shifts in DDR pairs, locks to the 32-bit frame boundary
// with hysteresis and emits one I/Q write per received data frame.
module lvds_rx_deframer
    import lvds_frame_pkg::*;
#(
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 3,
    parameter int ERR_W       = 16
) (
    input logic                clk,
    input logic                reset_n,
    lvds_rx_deframer_if.master bus
);
    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int BAD_W  = $clog2(LOSS_FRAMES + 1);
    localparam logic [PH_W-1:0]   PH_LAST     = PH_W'(PAIRS - 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_FRAMES);
    localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(LOSS_FRAMES);

    logic [FRAME_BITS-1:0] sr;
    logic [PH_W-1:0]       ph;
    rx_state_t             state;
    logic [GOOD_W-1:0]     good;
    logic [BAD_W-1:0]      bad;
    frame_cls_t            cls;
    logic                  frame_ok;
    logic                  boundary;
    logic [GOOD_W-1:0]     good_inc;
    logic [BAD_W-1:0]      bad_inc;

    logic [SAMPLE_W-1:0]   i_r;
    logic [SAMPLE_W-1:0]   q_r;
    logic                  valid_r;
    logic                  eom_r;
    logic                  locked_r;
    logic                  lost_r;
    logic [ERR_W-1:0]      err_r;

    lvds_frame_classify u_classify (
        .sr  (sr),
        .cls (cls)
    );

    assign frame_ok = (cls == CLS_DATA) || (cls == CLS_EOM);
    assign boundary = (ph == PH_LAST);
    assign good_inc = good + 1'b1;
    assign bad_inc  = bad + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr       <= '0;
            ph       <= '0;
            state    <= ST_HUNT;
            good     <= '0;
            bad      <= '0;
            i_r      <= '0;
            q_r      <= '0;
            valid_r  <= 1'b0;
            eom_r    <= 1'b0;
            locked_r <= 1'b0;
            lost_r   <= 1'b0;
            err_r    <= '0;
        end else begin
            // i_rx_d[0] is earlier on the wire, so it lands one bit above [1].
            sr      <= {sr[FRAME_BITS-3:0], bus.i_rx_d[0], bus.i_rx_d[1]};
            ph      <= ph + 1'b1;
            valid_r <= 1'b0;
            eom_r   <= 1'b0;
            lost_r  <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (frame_ok) begin
                        ph   <= '0;
                        good <= GOOD_W'(1);
                        if (LOCK_FRAMES == 1) begin
                            state    <= ST_LOCKED;
                            locked_r <= 1'b1;
                            bad      <= '0;
                        end else begin
                            state <= ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (boundary) begin
                        if (frame_ok) begin
                            good <= good_inc;
                            if (good_inc == GOOD_TARGET) begin
                                state    <= ST_LOCKED;
                                locked_r <= 1'b1;
                                bad      <= '0;
                            end
                        end else begin
                            state <= ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        case (cls)
                            CLS_DATA: begin
                                valid_r <= 1'b1;
                                i_r     <= sr[I_MSB:I_LSB];
                                q_r     <= sr[Q_MSB:Q_LSB];
                                bad     <= '0;
                            end
                            CLS_EOM: begin
                                eom_r <= 1'b1;
                                bad   <= '0;
                            end
                            CLS_IDLE: begin
                            end
                            CLS_BAD: begin
                                bad <= bad_inc;
                                if (err_r != '1) err_r <= err_r + 1'b1;
                                if (bad_inc == BAD_TARGET) begin
                                    state    <= ST_HUNT;
                                    locked_r <= 1'b0;
                                    lost_r   <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

    assign bus.o_i       = i_r;
    assign bus.o_q       = q_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_eom     = eom_r;
    assign bus.o_locked  = locked_r;
    assign bus.o_lost    = lost_r;
    assign bus.o_err_cnt = err_r;

endmodule

// File: tb/tb_lvds_rx_deframer.sv
// Bench for lvds_rx_deframer: two instances (4/3 hysteresis with 16-bit errors,
// 1/1 hysteresis with a 4-bit counter) against a frame-level reference model.
module tb_lvds_rx_deframer;

    localparam int K_IDLE = 0;
    localparam int K_DATA = 1;
    localparam int K_EOM  = 2;
    localparam int K_BAD  = 3;

    typedef struct {
        logic [31:0] word;
        bit          locked;
        bit          valid;
        bit          eom;
        bit          lost;
        logic [12:0] i;
        logic [12:0] q;
        int          err;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] rx_d = 2'b00;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lvds_rx_deframer_if #(.ERR_W(16)) bus_a ();
    lvds_rx_deframer_if #(.ERR_W(4))  bus_b ();
    assign bus_a.i_rx_d = rx_d;
    assign bus_b.i_rx_d = rx_d;

    lvds_rx_deframer #(.LOCK_FRAMES(4), .LOSS_FRAMES(3), .ERR_W(16)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    lvds_rx_deframer #(.LOCK_FRAMES(1), .LOSS_FRAMES(1), .ERR_W(4)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    // Reference model: one slot per instance, boundaries tracked as absolute edge times.
    int          lock_n [2] = '{4, 1};
    int          loss_n [2] = '{3, 1};
    int          err_max[2] = '{65535, 15};
    logic [31:0] m_w    [2];
    bit          m_lock [2];
    bit          m_conf [2];
    longint      m_due  [2];
    int          m_good [2];
    int          m_bad  [2];
    int          m_i    [2];
    int          m_q    [2];
    bit          m_valid[2];
    bit          m_eom  [2];
    bit          m_lost [2];
    int          m_err  [2];
    longint      cyc = 0;

    function automatic int kind_of(input logic [31:0] w);
        int unsigned v;
        v = w;
        if (v == 0) return K_IDLE;
        if ((v >> 30) != 2 || ((v >> 14) & 3) != 1 || (v & 1) != 0) return K_BAD;
        if (((v >> 16) & 1) == 1) return K_DATA;
        if (((v >> 17) & 'h1FFF) == 0 && ((v >> 1) & 'h1FFF) == 0) return K_EOM;
        return K_BAD;
    endfunction

    function automatic logic [31:0] mk_data(input logic [12:0] i, input logic [12:0] q);
        return {2'b10, i, 1'b1, 2'b01, q, 1'b0};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_w[k] = '0; m_lock[k] = 0; m_conf[k] = 0; m_due[k] = 0;
            m_good[k] = 0; m_bad[k] = 0; m_i[k] = 0; m_q[k] = 0;
            m_valid[k] = 0; m_eom[k] = 0; m_lost[k] = 0; m_err[k] = 0;
        end
    endtask

    task automatic model_edge(input logic [1:0] d);
        int          kind;
        bit          ok;
        int unsigned v;
        for (int k = 0; k < 2; k++) begin
            kind = kind_of(m_w[k]);
            ok   = (kind == K_DATA) || (kind == K_EOM);
            v    = m_w[k];
            m_valid[k] = 0; m_eom[k] = 0; m_lost[k] = 0;
            if (!m_lock[k] && !m_conf[k]) begin
                if (ok) begin
                    m_due[k]  = cyc + 16;
                    m_good[k] = 1;
                    if (m_good[k] == lock_n[k]) begin
                        m_lock[k] = 1; m_bad[k] = 0;
                    end else begin
                        m_conf[k] = 1;
                    end
                end
            end else if (cyc == m_due[k]) begin
                m_due[k] += 16;
                if (m_conf[k]) begin
                    if (!ok) begin
                        m_conf[k] = 0;
                    end else begin
                        m_good[k]++;
                        if (m_good[k] == lock_n[k]) begin
                            m_conf[k] = 0; m_lock[k] = 1; m_bad[k] = 0;
                        end
                    end
                end else if (kind == K_DATA) begin
                    m_valid[k] = 1; m_bad[k] = 0;
                    m_i[k] = int'((v >> 17) & 'h1FFF);
                    m_q[k] = int'((v >> 1) & 'h1FFF);
                end else if (kind == K_EOM) begin
                    m_eom[k] = 1; m_bad[k] = 0;
                end else if (kind == K_BAD) begin
                    m_bad[k]++;
                    if (m_err[k] < err_max[k]) m_err[k]++;
                    if (m_bad[k] == loss_n[k]) begin
                        m_lock[k] = 0; m_lost[k] = 1;
                    end
                end
            end
            m_w[k] = (m_w[k] << 2) | {30'd0, d[0], d[1]};
        end
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("a.valid",  int'(bus_a.o_valid),   int'(m_valid[0]));
        check("a.eom",    int'(bus_a.o_eom),     int'(m_eom[0]));
        check("a.lost",   int'(bus_a.o_lost),    int'(m_lost[0]));
        check("a.locked", int'(bus_a.o_locked),  int'(m_lock[0]));
        check("a.i",      int'(bus_a.o_i),       m_i[0]);
        check("a.q",      int'(bus_a.o_q),       m_q[0]);
        check("a.err",    int'(bus_a.o_err_cnt), m_err[0]);
        check("b.valid",  int'(bus_b.o_valid),   int'(m_valid[1]));
        check("b.eom",    int'(bus_b.o_eom),     int'(m_eom[1]));
        check("b.lost",   int'(bus_b.o_lost),    int'(m_lost[1]));
        check("b.locked", int'(bus_b.o_locked),  int'(m_lock[1]));
        check("b.i",      int'(bus_b.o_i),       m_i[1]);
        check("b.q",      int'(bus_b.o_q),       m_q[1]);
        check("b.err",    int'(bus_b.o_err_cnt), m_err[1]);
    endtask

    task automatic step(input logic [1:0] d);
        rx_d = d;
        @(posedge clk);
        if (reset_n) model_edge(d);
        else begin
            model_reset();
            cyc++;
        end
        #1;
        compare_all();
    endtask

    // Observation after the first pair reflects the frame that ended just before.
    task automatic send_word(input logic [31:0] w, output vec_t o);
        for (int p = 0; p < 16; p++) begin
            step({w[30 - 2*p], w[31 - 2*p]});
            if (p == 0) begin
                o.word   = w;
                o.locked = bus_a.o_locked;
                o.valid  = bus_a.o_valid;
                o.eom    = bus_a.o_eom;
                o.lost   = bus_a.o_lost;
                o.i      = bus_a.o_i;
                o.q      = bus_a.o_q;
                o.err    = int'(bus_a.o_err_cnt);
            end
        end
    endtask

    task automatic check_obs(input vec_t e, input vec_t o);
        check("tbl.locked", int'(o.locked), int'(e.locked));
        check("tbl.valid",  int'(o.valid),  int'(e.valid));
        check("tbl.eom",    int'(o.eom),    int'(e.eom));
        check("tbl.lost",   int'(o.lost),   int'(e.lost));
        check("tbl.i",      int'(o.i),      int'(e.i));
        check("tbl.q",      int'(o.q),      int'(e.q));
        check("tbl.err",    o.err,          e.err);
    endtask

    initial begin
        vec_t        tbl[15];
        vec_t        obs;
        logic [31:0] d1, d2, c1, w;
        logic [12:0] ri, rq, last_i, last_q;
        int unsigned r;

        d1 = mk_data(13'h0ABC, 13'h1F01);
        d2 = mk_data(13'h1000, 13'h0FFF);
        c1 = d1 ^ 32'h0001_0001;
        tbl[0]  = '{d1,            0, 0, 0, 0, 13'h0000, 13'h0000, 0};
        tbl[1]  = '{d1,            0, 0, 0, 0, 13'h0000, 13'h0000, 0};
        tbl[2]  = '{d1,            0, 0, 0, 0, 13'h0000, 13'h0000, 0};
        tbl[3]  = '{d1,            1, 0, 0, 0, 13'h0000, 13'h0000, 0};
        tbl[4]  = '{d2,            1, 1, 0, 0, 13'h1000, 13'h0FFF, 0};
        tbl[5]  = '{32'h8000_4000, 1, 0, 1, 0, 13'h1000, 13'h0FFF, 0};
        tbl[6]  = '{32'h0,         1, 0, 0, 0, 13'h1000, 13'h0FFF, 0};
        tbl[7]  = '{32'h0,         1, 0, 0, 0, 13'h1000, 13'h0FFF, 0};
        tbl[8]  = '{32'h0,         1, 0, 0, 0, 13'h1000, 13'h0FFF, 0};
        tbl[9]  = '{c1,            1, 0, 0, 0, 13'h1000, 13'h0FFF, 1};
        tbl[10] = '{c1,            1, 0, 0, 0, 13'h1000, 13'h0FFF, 2};
        tbl[11] = '{d1,            1, 1, 0, 0, 13'h0ABC, 13'h1F01, 2};
        tbl[12] = '{c1,            1, 0, 0, 0, 13'h0ABC, 13'h1F01, 3};
        tbl[13] = '{c1,            1, 0, 0, 0, 13'h0ABC, 13'h1F01, 4};
        tbl[14] = '{c1,            0, 0, 0, 1, 13'h0ABC, 13'h1F01, 5};

        // Reset state
        model_reset();
        #1;
        compare_all();
        step(2'b00);
        step(2'b00);
        reset_n = 1'b1;

        // Odd pair offset before the first frame, then the lock/err table
        for (int p = 0; p < 5; p++) step(2'b00);
        for (int n = 0; n < 15; n++) begin
            send_word(tbl[n].word, obs);
            if (n > 0) check_obs(tbl[n-1], obs);
        end
        send_word(32'h0, obs);
        check_obs(tbl[14], obs);

        // Pair slip while locked: Q[0]=0 makes every misaligned window BAD
        for (int f = 0; f < 6; f++) begin
            ri = 13'($urandom); rq = 13'($urandom) & 13'h1FFE;
            send_word(mk_data(ri, rq), obs);
        end
        step(2'b00);
        for (int f = 0; f < 20; f++) begin
            ri = 13'($urandom); rq = 13'($urandom) & 13'h1FFE;
            last_i = ri; last_q = rq;
            send_word(mk_data(ri, rq), obs);
        end
        send_word(32'h0, obs);
        check("slip.locked", int'(obs.locked), 1);
        check("slip.valid",  int'(obs.valid),  1);
        check("slip.i",      int'(obs.i),      int'(last_i));
        check("slip.q",      int'(obs.q),      int'(last_q));
        check("slip.err",    obs.err,          8);

        // Asynchronous reset mid-frame while locked
        send_word(d2, obs);
        for (int p = 0; p < 7; p++) step({d1[30 - 2*p], d1[31 - 2*p]});
        check("pre_rst.locked", int'(bus_a.o_locked), 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst.a.locked", int'(bus_a.o_locked),  0);
        check("rst.a.i",      int'(bus_a.o_i),       0);
        check("rst.a.q",      int'(bus_a.o_q),       0);
        check("rst.a.err",    int'(bus_a.o_err_cnt), 0);
        check("rst.b.locked", int'(bus_b.o_locked),  0);
        check("rst.b.err",    int'(bus_b.o_err_cnt), 0);
        @(negedge clk);
        step(2'b00);
        step(2'b00);
        reset_n = 1'b1;
        for (int p = 0; p < 3; p++) step(2'b00);
        for (int f = 0; f < 4; f++) send_word(d1, obs);
        check("relock.pre4", int'(obs.locked), 0);
        send_word(32'h0, obs);
        check("relock.post4", int'(obs.locked), 1);
        check("relock.valid", int'(obs.valid),  0);

        // Randomized traffic with occasional pair slips
        for (int f = 0; f < 150; f++) begin
            r  = $urandom_range(0, 99);
            ri = 13'($urandom);
            rq = 13'($urandom);
            if ($urandom_range(0, 19) == 0) step(2'($urandom));
            if (r < 50)      w = mk_data(ri, rq);
            else if (r < 60) w = 32'h8000_4000;
            else if (r < 75) w = 32'h0;
            else if (r < 90) w = mk_data(ri, rq) ^ 32'h0001_0001;
            else             w = $urandom;
            send_word(w, obs);
        end

        // 1/1 instance: relocks on each good frame, so alternating bad frames saturate its counter
        for (int f = 0; f < 17; f++) begin
            send_word(d1, obs);
            send_word(c1, obs);
        end
        send_word(32'h0, obs);
        check("sat.b.err", int'(bus_b.o_err_cnt), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
